// File: rtl/toggle_event_collector.sv
// Per-bit toggle event collector: detects rising and falling edges on a monitored bus,
// keeps a sticky coverage bitmap with a population count, and dumps the bitmap over a handshake.
module toggle_event_collector #(
  parameter  int WIDTH      = 65,
  parameter  int FIRST_ONLY = 1,
  parameter  int DUMP_W     = 32,
  localparam int NPTS       = 2 * WIDTH,
  localparam int NWORDS     = (NPTS + DUMP_W - 1) / DUMP_W,
  localparam int CW         = $clog2(NPTS + 1),
  localparam int IW         = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic [WIDTH-1:0]  sample,
  output logic [NPTS-1:0]   valid,
  output logic [CW-1:0]     covered_cnt,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DUMP_W-1:0] dump_data,
  output logic              dump_last,
  output logic              dump_busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic                primed_q, primed_d;
  logic [NPTS-1:0]     bitmap_q, bitmap_d;
  logic [NPTS-1:0]     valid_q, valid_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DUMP_W-1:0]   data_q, data_d;
  logic                last_q, last_d;

  logic [NPTS-1:0]     raw;
  logic [NPTS-1:0]     new_pts;
  logic [CW-1:0]       cnt_add;
  logic [NWORDS*DUMP_W-1:0] bm_pad;
  logic [IW-1:0]       nxt_idx;
  logic [DUMP_W-1:0]   nxt_word;

  // Event detection, sticky bitmap and coverage count
  always_comb begin
    raw     = '0;
    cnt_add = '0;
    if (primed_q && en && !clear) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        raw[2*i]   = !prev_q[i] &&  sample[i];
        raw[2*i+1] =  prev_q[i] && !sample[i];
      end
    end
    new_pts = raw & ~bitmap_q;
    for (int unsigned i = 0; i < NPTS; i++) begin
      cnt_add = cnt_add + CW'(new_pts[i]);
    end
    prev_d   = sample;
    primed_d = !clear;
    if (clear) begin
      valid_d  = '0;
      bitmap_d = '0;
      cnt_d    = '0;
    end else begin
      valid_d  = (FIRST_ONLY != 0) ? new_pts : raw;
      bitmap_d = bitmap_q | raw;
      cnt_d    = cnt_q + cnt_add;
    end
  end

  // Beat selection: word 0 when starting from IDLE, otherwise the word after the current one
  always_comb begin
    bm_pad = '0;
    bm_pad[NPTS-1:0] = bitmap_q;
    if (state_q == IDLE || idx_q == IW'(NWORDS - 1)) begin
      nxt_idx = (state_q == IDLE) ? '0 : idx_q;
    end else begin
      nxt_idx = idx_q + IW'(1);
    end
    nxt_word = bm_pad[int'(nxt_idx)*DUMP_W +: DUMP_W];
  end

  // Dump FSM next state and beat registers
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
      data_d  = '0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_req) begin
            state_d = SEND;
            idx_d   = nxt_idx;
            data_d  = nxt_word;
            last_d  = (nxt_idx == IW'(NWORDS - 1));
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (last_q) begin
              state_d = IDLE;
              idx_d   = '0;
              data_d  = '0;
              last_d  = 1'b0;
            end else begin
              idx_d  = nxt_idx;
              data_d = nxt_word;
              last_d = (nxt_idx == IW'(NWORDS - 1));
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      primed_q <= 1'b0;
      bitmap_q <= '0;
      valid_q  <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
      bitmap_q <= bitmap_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    dump_valid  = (state_q == SEND);
    dump_busy   = (state_q == SEND);
    dump_data   = data_q;
    dump_last   = last_q;
    valid       = valid_q;
    covered_cnt = cnt_q;
  end

endmodule
